// File: rtl/systolic_feed_sequencer.sv
// Feed sequencer for Systolic_array: stores one vector and a PE_NUMBER-column matrix, then clears,
// streams the skewed diagonal feed, drains and holds read. Optional cycle counter: SEQ_PERF_CNT_EN.
module systolic_feed_sequencer #(
    parameter int PE_NUMBER    = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_LEN      = 8,
    parameter int CLR_CYCLES   = 3,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [$clog2(MAX_LEN+1)-1:0]       len,
    input  logic                               rd_ack,
    input  logic                               vec_wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]         vec_wr_addr,
    input  logic [DATA_WIDTH-1:0]              vec_wr_data,
    input  logic                               mat_wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]         mat_wr_row,
    input  logic [$clog2(PE_NUMBER)-1:0]       mat_wr_col,
    input  logic [DATA_WIDTH-1:0]              mat_wr_data,
    output logic                               sa_reset,
    output logic [DATA_WIDTH-1:0]              l_d_i,
    output logic [PE_NUMBER*DATA_WIDTH-1:0]    pe_t_w,
    output logic                               sa_read,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [31:0]                        perf_cycles
);
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int AW      = $clog2(MAX_LEN);
    localparam int CLW     = $clog2(PE_NUMBER);
    localparam int CNT_MAX = MAX_LEN + PE_NUMBER + CLR_CYCLES + DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, READ} state_t;

    state_t          state_q;
    logic [LW-1:0]   k_q;
    logic [CW-1:0]   cnt_q;
    logic            sa_reset_q, sa_read_q, busy_q, done_q, err_q;
    logic [DATA_WIDTH-1:0] l_d_q;

    logic            start_ok;
    logic [CW-1:0]   s_total;
    logic            feed_valid;
    logic [CW-1:0]   feed_step;
    logic            vec_addr_ok, mat_row_ok, mat_col_ok;
    logic            vec_we, mat_we;
    logic [DATA_WIDTH-1:0] vec_mem [MAX_LEN];

    assign start_ok = start && (len != '0) && (len <= LW'(MAX_LEN));
    assign s_total  = CW'(k_q) + CW'(PE_NUMBER - 1);

    // The first diagonal (s=0) is registered on the last CLEAR edge so FEED starts with valid data.
    assign feed_valid = ((state_q == CLEAR) && (cnt_q == CW'(CLR_CYCLES - 1))) ||
                        ((state_q == FEED) && (cnt_q != s_total));
    assign feed_step  = (state_q == FEED) ? cnt_q : '0;

    generate
        if (MAX_LEN == (1 << AW)) begin : g_addr_full
            assign vec_addr_ok = 1'b1;
            assign mat_row_ok  = 1'b1;
        end else begin : g_addr_chk
            assign vec_addr_ok = (vec_wr_addr < AW'(MAX_LEN));
            assign mat_row_ok  = (mat_wr_row < AW'(MAX_LEN));
        end
        if (PE_NUMBER == (1 << CLW)) begin : g_col_full
            assign mat_col_ok = 1'b1;
        end else begin : g_col_chk
            assign mat_col_ok = (mat_wr_col < CLW'(PE_NUMBER));
        end
    endgenerate

    assign vec_we = vec_wr_en && vec_addr_ok && (state_q == IDLE);
    assign mat_we = mat_wr_en && mat_row_ok && mat_col_ok && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (vec_we) begin
            vec_mem[vec_wr_addr] <= vec_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_d_q <= '0;
        end else if (feed_valid && (feed_step < CW'(k_q))) begin
            l_d_q <= vec_mem[feed_step[AW-1:0]];
        end else begin
            l_d_q <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PE_NUMBER; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] col_mem [MAX_LEN];
            logic [DATA_WIDTH-1:0] lane_q;
            logic [CW:0]           diff;
            logic                  hit;

            // Lane gi lags the vector by gi steps; the extra MSB flags s < gi.
            assign diff = {1'b0, feed_step} - (CW + 1)'(gi);
            assign hit  = feed_valid && !diff[CW] && (diff[CW-1:0] < CW'(k_q));

            always_ff @(posedge clk) begin
                if (mat_we && (mat_wr_col == CLW'(gi))) begin
                    col_mem[mat_wr_row] <= mat_wr_data;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_q <= '0;
                end else if (hit) begin
                    lane_q <= col_mem[diff[AW-1:0]];
                end else begin
                    lane_q <= '0;
                end
            end

            assign pe_t_w[gi*DATA_WIDTH +: DATA_WIDTH] = lane_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            sa_reset_q <= 1'b0;
            sa_read_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        k_q        <= len;
                        cnt_q      <= '0;
                        sa_reset_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= CLEAR;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == CW'(CLR_CYCLES - 1)) begin
                        sa_reset_q <= 1'b0;
                        cnt_q      <= CW'(1);
                        state_q    <= FEED;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FEED: begin
                    if (cnt_q == s_total) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                        sa_read_q <= 1'b1;
                        state_q   <= READ;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                READ: begin
                    if (rd_ack) begin
                        sa_read_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sa_reset = sa_reset_q;
    assign l_d_i    = l_d_q;
    assign sa_read  = sa_read_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d, perf_q;

    assign perf_cnt_d = (busy_q && (perf_cnt_q != '1)) ? perf_cnt_q + 32'd1 : perf_cnt_q;

    // The snapshot taken on the done edge includes the final READ cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            if ((state_q == IDLE) && start_ok) begin
                perf_cnt_q <= '0;
            end else begin
                perf_cnt_q <= perf_cnt_d;
            end
            if ((state_q == READ) && rd_ack) begin
                perf_q <= perf_cnt_d;
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Self-checking bench for systolic_feed_sequencer: directed and randomized operations compared each
// cycle against a cycle-schedule reference model of the store and the feed diagonals.
module tb_systolic_feed_sequencer;
    localparam int P   = 3;
    localparam int DW  = 16;
    localparam int ML  = 8;
    localparam int CLR = 3;
    localparam int DRN = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [3:0]     len;
    logic           rd_ack;
    logic           vec_wr_en;
    logic [2:0]     vec_wr_addr;
    logic [DW-1:0]  vec_wr_data;
    logic           mat_wr_en;
    logic [2:0]     mat_wr_row;
    logic [1:0]     mat_wr_col;
    logic [DW-1:0]  mat_wr_data;
    logic           sa_reset;
    logic [DW-1:0]  l_d_i;
    logic [P*DW-1:0] pe_t_w;
    logic           sa_read;
    logic           busy;
    logic           done;
    logic           err;
    logic [31:0]    perf_cycles;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] vec_m [ML];
    logic [DW-1:0] mat_m [ML][P];
    logic [31:0]   perf_m = 32'd0;

    systolic_feed_sequencer #(
        .PE_NUMBER(P), .DATA_WIDTH(DW), .MAX_LEN(ML), .CLR_CYCLES(CLR), .DRAIN_CYCLES(DRN)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .rd_ack(rd_ack),
        .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
        .mat_wr_en(mat_wr_en), .mat_wr_row(mat_wr_row), .mat_wr_col(mat_wr_col),
        .mat_wr_data(mat_wr_data), .sa_reset(sa_reset), .l_d_i(l_d_i), .pe_t_w(pe_t_w),
        .sa_read(sa_read), .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string ph, input int c, input logic e_rst, input logic [DW-1:0] e_l,
                              input logic [P*DW-1:0] e_pe, input logic e_rd, input logic e_busy,
                              input logic e_done, input logic e_err);
        chk($sformatf("%s c%0d sa_reset", ph, c), 64'(sa_reset), 64'(e_rst));
        chk($sformatf("%s c%0d l_d_i", ph, c), 64'(l_d_i), 64'(e_l));
        chk($sformatf("%s c%0d pe_t_w", ph, c), 64'(pe_t_w), 64'(e_pe));
        chk($sformatf("%s c%0d sa_read", ph, c), 64'(sa_read), 64'(e_rd));
        chk($sformatf("%s c%0d busy", ph, c), 64'(busy), 64'(e_busy));
        chk($sformatf("%s c%0d done", ph, c), 64'(done), 64'(e_done));
        chk($sformatf("%s c%0d err", ph, c), 64'(err), 64'(e_err));
        chk($sformatf("%s c%0d perf", ph, c), 64'(perf_cycles), 64'(perf_m));
    endtask

    task automatic clear_inputs();
        start = 1'b0; len = 4'd0; rd_ack = 1'b0;
        vec_wr_en = 1'b0; vec_wr_addr = 3'd0; vec_wr_data = '0;
        mat_wr_en = 1'b0; mat_wr_row = 3'd0; mat_wr_col = 2'd0; mat_wr_data = '0;
    endtask

    task automatic wr_vec(input int a, input logic [DW-1:0] d);
        vec_wr_en = 1'b1; vec_wr_addr = 3'(a); vec_wr_data = d;
        @(negedge clk);
        vec_wr_en = 1'b0;
        if (a < ML) vec_m[a] = d;
    endtask

    task automatic wr_mat(input int r, input int c, input logic [DW-1:0] d);
        mat_wr_en = 1'b1; mat_wr_row = 3'(r); mat_wr_col = 2'(c); mat_wr_data = d;
        @(negedge clk);
        mat_wr_en = 1'b0;
        if (r < ML && c < P) mat_m[r][c] = d;
    endtask

    task automatic bad_start(input int l);
        $display("bad_start len=%0d", l);
        start = 1'b1; len = 4'(l);
        @(negedge clk);
        check_outs("badlen", 1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check_outs("badlen", 2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected outputs come from the cycle schedule: clear window, diagonal window, drain, read.
    task automatic run_op(input string ph, input int k, input int ack_wait, input int abort_at,
                          input bit same_wr, input bit poke_vec0);
        int s_tot, r0, done_c, s, a;
        logic e_rst, e_rd, feeding;
        logic [DW-1:0] e_l, d;
        logic [P*DW-1:0] e_pe;
        s_tot  = k + P - 1;
        r0     = CLR + s_tot + DRN + 1;
        done_c = r0 + ack_wait + 1;
        $display("op %s len=%0d ack_wait=%0d abort_at=%0d same_wr=%0d", ph, k, ack_wait, abort_at, same_wr);
        start = 1'b1; len = 4'(k);
        if (same_wr) begin
            a = $urandom_range(0, ML - 1);
            d = DW'($urandom);
            vec_wr_en = 1'b1; vec_wr_addr = 3'(a); vec_wr_data = d;
            vec_m[a] = d;
        end
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            e_rst = (c >= 1) && (c <= CLR);
            s = c - CLR - 1;
            feeding = (s >= 0) && (s < s_tot);
            e_l = (feeding && s < k) ? vec_m[s] : '0;
            e_pe = '0;
            for (int j = 0; j < P; j++) begin
                if (feeding && s >= j && s < j + k) e_pe[j*DW +: DW] = mat_m[s-j][j];
            end
            e_rd = (c >= r0) && (c < done_c);
`ifdef SEQ_PERF_CNT_EN
            if (c == done_c) perf_m = 32'(done_c - 1);
`endif
            check_outs(ph, c, e_rst, e_l, e_pe, e_rd, c < done_c, c == done_c, 1'b0);
            if (c == abort_at) begin
                reset = 1'b1;
                clear_inputs();
                perf_m = 32'd0;
                #1;
                check_outs({ph, "_rst"}, c, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                check_outs({ph, "_rst"}, c + 1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                reset = 1'b0;
                @(negedge clk);
                check_outs({ph, "_post"}, c + 2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (c < done_c) begin
                // Busy-time noise: starts, writes and early acks must all be ignored.
                start = 1'($urandom_range(0, 1)); len = 4'($urandom_range(0, 15));
                vec_wr_en = 1'($urandom_range(0, 1)); vec_wr_addr = 3'($urandom_range(0, 7));
                vec_wr_data = DW'($urandom);
                mat_wr_en = 1'($urandom_range(0, 1)); mat_wr_row = 3'($urandom_range(0, 7));
                mat_wr_col = 2'($urandom_range(0, 3)); mat_wr_data = DW'($urandom);
                if (poke_vec0 && c == CLR + 1) begin
                    vec_wr_en = 1'b1; vec_wr_addr = 3'd0; vec_wr_data = 16'd99;
                end
                rd_ack = (c < r0) ? 1'($urandom_range(0, 1)) : (c == r0 + ack_wait);
            end else begin
                clear_inputs();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_outs("idle", 0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int a = 0; a < ML; a++) begin
            wr_vec(a, DW'($urandom));
            for (int j = 0; j < P; j++) wr_mat(a, j, DW'($urandom));
        end
        wr_mat(0, 3, 16'hBEEF);

        wr_vec(0, 16'd8); wr_vec(1, 16'd10); wr_vec(2, 16'd4);
        wr_mat(0, 0, 16'd1); wr_mat(1, 0, 16'd7); wr_mat(2, 0, 16'd9);
        wr_mat(0, 1, 16'd6); wr_mat(1, 1, 16'd3); wr_mat(2, 1, 16'd5);
        wr_mat(0, 2, 16'd2); wr_mat(1, 2, 16'd7); wr_mat(2, 2, 16'd2);

        run_op("basic", 3, 1, 0, 1'b0, 1'b0);
        run_op("handshake", 3, 5, 0, 1'b0, 1'b0);
        bad_start(0);
        bad_start(9);
        bad_start(15);
        run_op("len1", 1, 0, 0, 1'b0, 1'b0);
        run_op("busywr", 3, 1, 0, 1'b0, 1'b1);
        run_op("busywr2", 3, 2, 0, 1'b0, 1'b0);
        run_op("abort", 3, 1, 6, 1'b0, 1'b0);
        run_op("after_rst", 3, 1, 0, 1'b0, 1'b0);
        run_op("maxlen", 8, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) wr_vec($urandom_range(0, ML - 1), DW'($urandom));
            repeat ($urandom_range(0, 3)) wr_mat($urandom_range(0, ML - 1), $urandom_range(0, 3), DW'($urandom));
            run_op("rand", $urandom_range(1, ML), $urandom_range(0, 4), 0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feed_sequencer.md
Name: systolic_feed_sequencer

Overview:
- Sequencer placed between the CSR/controller layer and Systolic_array.
- Stores one input vector and one PE_NUMBER-column weight matrix loaded over simple write ports.
- On start, it clears the array, then streams the skewed diagonal feed on l_d_i/pe_t_w, drains the array, and raises read until the result is acknowledged.

Parameters:
- PE_NUMBER, 3: number of PEs / matrix columns.
- DATA_WIDTH, 16: element width.
- MAX_LEN, 8: maximum vector length K (matrix rows).
- CLR_CYCLES, 3: cycles sa_reset is held high before feeding.
- DRAIN_CYCLES, 1: zero-feed cycles after the last diagonal.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start request; sampled only in IDLE.
- len  in  $clog2(MAX_LEN+1)  K, sampled with start.
- rd_ack  in  1  consumer has captured results; ends READ.
- vec_wr_en  in  1  vector store write.
- vec_wr_addr  in  $clog2(MAX_LEN)  vector index.
- vec_wr_data  in  DATA_WIDTH  vector element.
- mat_wr_en  in  1  matrix store write.
- mat_wr_row  in  $clog2(MAX_LEN)  row index k.
- mat_wr_col  in  $clog2(PE_NUMBER)  column/PE index j.
- mat_wr_data  in  DATA_WIDTH  element.
- sa_reset  out  1  clear to Systolic_array.reset.
- l_d_i  out  DATA_WIDTH  left data to the array.
- pe_t_w  out  PE_NUMBER*DATA_WIDTH  packed top weights; lane j = bits [j*DATA_WIDTH +: DATA_WIDTH].
- sa_read  out  1  to Systolic_array.read.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse on a rejected start.
- perf_cycles  out  32  see Optional Feature.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Store contents are not reset.
- All outputs are registered. "Cycle n" means the value after posedge n.
- Storage writes:
  - Accepted only in IDLE, one cycle after the write enable is sampled.
  - Ignored (no error) in any other state.
  - Out-of-range addresses are ignored.
- FSM states: IDLE, CLEAR, FEED, DRAIN, READ.
- IDLE:
  - If start=1 and 1<=len<=MAX_LEN: latch K=len and go to CLEAR.
  - If start=1 with len=0 or len>MAX_LEN: err=1 for one cycle, stay in IDLE.
  - If start and a write occur in the same cycle: the write is applied and start is accepted; the new data is used.
- CLEAR:
  - sa_reset=1 for exactly CLR_CYCLES cycles; feed outputs 0.
  - Then go to FEED with step counter s=0.
- FEED runs S = K+PE_NUMBER-1 cycles, s=0..S-1. In each cycle:
  - l_d_i = vec[s] if s<K, else 0.
  - Lane j: pe_t_w = mat[s-j][j] if j<=s<j+K, else 0.
  - After s=S-1, go to DRAIN.
- DRAIN: all feed outputs 0 for DRAIN_CYCLES cycles, then go to READ.
- READ:
  - sa_read=1 until rd_ack is sampled high.
  - The cycle after rd_ack: sa_read=0, done=1 for one cycle, state IDLE, busy=0.
  - rd_ack outside READ is ignored.
- start in any non-IDLE state is ignored and does not set err.
- Asynchronous reset mid-operation immediately forces IDLE and zero outputs. No done pulse is generated.
- Counters are sized to MAX_LEN+PE_NUMBER. The step counter never wraps within an operation.
- Total latency from start acceptance to the first sa_read: CLR_CYCLES + S + DRAIN_CYCLES + 1 cycles.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - A 32-bit counter clears when start is accepted and increments every busy cycle.
  - On done, its value is copied into perf_cycles, which holds until the next done.
  - The counter saturates at 0xFFFF_FFFF.
- Undefined: no counter logic; perf_cycles is tied to 0.

Test Plan:
- Basic feed:
  - Stimulus: defaults; load vec={8,10,4} and mat columns j0={1,7,9}, j1={6,3,5}, j2={2,7,2}; start with len=3 at cycle 0.
  - Required: sa_reset high in cycles 1-3; FEED in cycles 4-8.
  - Cycle 4: l_d_i=8, pe_t_w={0,0,1}.
  - Cycle 6: l_d_i=4, lanes j0..j2 = {9,3,2}.
  - Cycle 8: l_d_i=0, lane2=2, other lanes 0.
  - Cycle 9: all zero. Cycle 10: sa_read=1.
- Handshake:
  - Stimulus: hold rd_ack low for 5 cycles of READ, then pulse it.
  - Required: sa_read stays 1 throughout; the next cycle gives sa_read=0, done=1, busy=0; done is exactly one cycle wide.
- Length bounds:
  - Stimulus: start with len=0, then len=9 (MAX_LEN=8).
  - Required: err pulses once for each start; busy stays 0; no sa_reset.
- len=1:
  - Required: FEED lasts 3 cycles; lane j is non-zero only at s=j.
- Busy-time writes:
  - Stimulus: write vec[0]=99 during FEED, then run a second start.
  - Required: the first op is unaffected; the second op still uses the old vec[0].
- Mid-operation reset:
  - Stimulus: assert reset during FEED.
  - Required: all outputs go to 0 immediately and no done pulse appears.
  - Required: a start after reset runs a full sequence; with SEQ_PERF_CNT_EN, perf_cycles=11 for the basic case (busy cycles 1-11).
